// File: rtl/vlsu_pkg.sv
// Shared types and constants for the vector load/store sequencer.
package vlsu_pkg;

  localparam int VLSU_WIDTH     = 32;
  localparam int VLSU_VEC_WIDTH = 64;
  localparam int VLSU_LEN_W     = 5;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_DRAIN,
    ST_RESP
  } state_t;

endpackage

// File: rtl/vlsu_addr_gen.sv
// Beat address generator: latches base/stride/len on start and walks the
// strided address one beat per step. Address arithmetic wraps mod 2**WIDTH.
module vlsu_addr_gen
  import vlsu_pkg::*;
#(
  parameter int WIDTH = VLSU_WIDTH,
  parameter int LEN_W = VLSU_LEN_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_start,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_base,
  input  logic [WIDTH-1:0] i_stride,
  input  logic [LEN_W-1:0] i_len,
  output logic [WIDTH-1:0] o_addr,
  output logic [LEN_W-1:0] o_beat,
  output logic             o_last
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_stride;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_beat;

  // Latch the request on start, then advance address and beat on each step.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_addr   <= '0;
      r_stride <= '0;
      r_len    <= '0;
      r_beat   <= '0;
    end else if (i_start) begin
      r_addr   <= i_base;
      r_stride <= i_stride;
      r_len    <= i_len;
      r_beat   <= '0;
    end else if (i_step) begin
      r_addr <= r_addr + r_stride;
      r_beat <= r_beat + ONE;
    end
  end

  assign o_addr = r_addr;
  assign o_beat = r_beat;
  assign o_last = (r_beat == (r_len - ONE));

endmodule

// File: rtl/vec_lsu.sv
// Vector load/store sequencer in front of the 64-bit vector data cache.
// One strided request is turned into one cache access per beat; load beats
// leave through a registered stream with backpressure.
// Optional: define VLSU_ALIGN_CHECK_EN to reject requests whose base or
// stride is not 8-byte aligned (done with err=1, no cache strobes).
module vec_lsu
  import vlsu_pkg::*;
#(
  parameter int WIDTH     = VLSU_WIDTH,
  parameter int VEC_WIDTH = VLSU_VEC_WIDTH,
  parameter int LEN_W     = VLSU_LEN_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_store,
  input  logic [WIDTH-1:0]     i_req_base,
  input  logic [WIDTH-1:0]     i_req_stride,
  input  logic [LEN_W-1:0]     i_req_len,
  output logic [WIDTH-1:0]     o_mem_address,
  output logic [VEC_WIDTH-1:0] o_mem_wdata,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  input  logic [VEC_WIDTH-1:0] i_mem_rdata,
  input  logic                 i_mem_valid,
  input  logic                 i_st_valid,
  output logic                 o_st_ready,
  input  logic [VEC_WIDTH-1:0] i_st_data,
  output logic                 o_ld_valid,
  input  logic                 i_ld_ready,
  output logic [VEC_WIDTH-1:0] o_ld_data,
  output logic [LEN_W-1:0]     o_ld_idx,
  output logic                 o_ld_last,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  state_t r_state;
  state_t w_next;

  logic                 w_start;
  logic                 w_step;
  logic                 w_cap;
  logic                 w_misalign;
  logic [WIDTH-1:0]     w_addr;
  logic [LEN_W-1:0]     w_beat;
  logic                 w_last;

  logic                 r_ld_valid;
  logic [VEC_WIDTH-1:0] r_ld_data;
  logic [LEN_W-1:0]     r_ld_idx;
  logic                 r_ld_last;
  logic                 r_err;

`ifdef VLSU_ALIGN_CHECK_EN
  assign w_misalign = (i_req_base[2:0] != 3'b000) || (i_req_stride[2:0] != 3'b000);
`else
  assign w_misalign = 1'b0;
`endif

  vlsu_addr_gen #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_addr_gen (
    .CLK      (CLK),
    .RST      (RST),
    .i_start  (w_start),
    .i_step   (w_step),
    .i_base   (i_req_base),
    .i_stride (i_req_stride),
    .i_len    (i_req_len),
    .o_addr   (w_addr),
    .o_beat   (w_beat),
    .o_last   (w_last)
  );

  // State register; reset aborts any request in flight without a done pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_next      = r_state;
    o_req_ready = 1'b0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_st_ready  = 1'b0;
    o_done      = 1'b0;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_start = 1'b1;
          if (w_misalign || (i_req_len == '0)) w_next = ST_RESP;
          else if (i_req_store == OP_STORE)    w_next = ST_STORE;
          else                                 w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        o_mem_read = 1'b1;
        // A new beat may land in the output register as the old one leaves.
        w_cap  = i_mem_valid && (!r_ld_valid || i_ld_ready);
        w_step = w_cap;
        if (w_cap && w_last) w_next = ST_DRAIN;
      end
      ST_STORE: begin
        o_st_ready  = 1'b1;
        o_mem_write = i_st_valid;
        w_step      = i_st_valid;
        if (i_st_valid && w_last) w_next = ST_RESP;
      end
      ST_DRAIN: begin
        if (r_ld_valid && i_ld_ready) w_next = ST_RESP;
      end
      ST_RESP: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Load output register: load on capture, drop valid once consumed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ld_valid <= 1'b0;
      r_ld_data  <= '0;
      r_ld_idx   <= '0;
      r_ld_last  <= 1'b0;
    end else if (w_cap) begin
      r_ld_valid <= 1'b1;
      r_ld_data  <= i_mem_rdata;
      r_ld_idx   <= w_beat;
      r_ld_last  <= w_last;
    end else if (i_ld_ready) begin
      r_ld_valid <= 1'b0;
    end
  end

  // Error flag is decided at accept and presented with done.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          r_err <= 1'b0;
    else if (w_start) r_err <= w_misalign;
  end

  assign o_mem_address = w_addr;
  assign o_mem_wdata   = (r_state == ST_STORE) ? i_st_data : '0;
  assign o_ld_valid    = r_ld_valid;
  assign o_ld_data     = r_ld_data;
  assign o_ld_idx      = r_ld_idx;
  assign o_ld_last     = r_ld_last;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_err         = (r_state == ST_RESP) && r_err;

endmodule
